// File: rtl/pipeline_issue_arbiter.sv
// pipeline_issue_arbiter
// Shares one multi-cycle datapath between two requesters. Round-robin grant,
// with a per-requester cap on operations in flight. Operands are registered
// into the datapath, and an owner tag travels alongside each operation so that
// every result can be routed back to its owner when it emerges.

module pipeline_issue_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [4*WIDTH-1:0] req0_ops,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [4*WIDTH-1:0] req1_ops,
  output logic               req1_ready,
  output logic [WIDTH-1:0]   dp_a1,
  output logic [WIDTH-1:0]   dp_b1,
  output logic [WIDTH-1:0]   dp_a2,
  output logic [WIDTH-1:0]   dp_b2,
  input  logic [WIDTH-1:0]   dp_c,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_data,
  output logic               busy
);

  localparam int            CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  // One in-flight slot: valid bit plus the requester that owns it.
  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  logic [4*WIDTH-1:0] ops_q, ops_d;
  logic               last_grant_q, last_grant_d;
  logic [CW-1:0]      cnt0_q, cnt0_d;
  logic [CW-1:0]      cnt1_q, cnt1_d;
  // tag_q[0] is loaded on the issue edge; tag_q[LATENCY] lines up with dp_c.
  tag_t               tag_q [LATENCY+1];
  tag_t               tag_d [LATENCY+1];

  logic elig0, elig1;
  logic grant0, grant1;
  logic issue;
  logic retire0, retire1;

  // Eligibility and round-robin grant; nothing is granted while reset is high.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    elig0  = req0_valid && (cnt0_q < MAX_CNT);
    elig1  = req1_valid && (cnt1_q < MAX_CNT);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig0 && elig1) begin
        // Tie goes to whoever did not win last.
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign issue      = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign dp_a1 = ops_q[4*WIDTH-1 -: WIDTH];
  assign dp_b1 = ops_q[3*WIDTH-1 -: WIDTH];
  assign dp_a2 = ops_q[2*WIDTH-1 -: WIDTH];
  assign dp_b2 = ops_q[WIDTH-1   -: WIDTH];

  // The datapath result is only reported when a live tag lines up with it, so
  // anything the unreset datapath emits in the meantime is masked to zero.
  assign resp_valid = tag_q[LATENCY].v;
  assign resp_id    = tag_q[LATENCY].id;
  assign resp_data  = resp_valid ? dp_c : '0;
  assign retire0    = resp_valid && !resp_id;
  assign retire1    = resp_valid &&  resp_id;

  // Busy while any slot of the tag pipe holds a live operation.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= LATENCY; i++) begin
      busy = busy | tag_q[i].v;
    end
  end

  // Next state: operand capture, tag shift and credit accounting.
  always_comb begin
    ops_d        = ops_q;
    last_grant_d = last_grant_q;
    if (grant0) begin
      ops_d        = req0_ops;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      ops_d        = req1_ops;
      last_grant_d = 1'b1;
    end

    // A cycle without an issue inserts a bubble; the pipe never stalls.
    tag_d[0] = '{v: issue, id: grant1};
    for (int i = 1; i <= LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    // Issue and retire on the same edge cancel out.
    cnt0_d = cnt0_q;
    case ({grant0, retire0})
      2'b10:   cnt0_d = cnt0_q + CW'(1);
      2'b01:   cnt0_d = cnt0_q - CW'(1);
      default: cnt0_d = cnt0_q;
    endcase

    cnt1_d = cnt1_q;
    case ({grant1, retire1})
      2'b10:   cnt1_d = cnt1_q + CW'(1);
      2'b01:   cnt1_d = cnt1_q - CW'(1);
      default: cnt1_d = cnt1_q;
    endcase
  end

  // State registers; reset drops every in-flight tag so their results are lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_q        <= '0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      // The tag pipe is a handful of flops whose valid bits gate every output,
      // so it is reset in full rather than treated as unreset storage.
      for (int i = 0; i <= LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      ops_q        <= ops_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      for (int i = 0; i <= LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipeline_issue_arbiter.sv
// Testbench for pipeline_issue_arbiter. A behavioural datapath computes
// C = A1*B1 + A2*B2 with LATENCY register stages (not reset). A scoreboard
// queue records the owner and expected C of every issue and is drained as
// responses emerge.

module tb_pipeline_issue_arbiter;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;
  localparam int MAX_OUT = 2;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] c;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               req0_valid, req1_valid;
  logic [4*WIDTH-1:0] req0_ops, req1_ops;
  logic               req0_ready, req1_ready;
  logic [WIDTH-1:0]   dp_a1, dp_b1, dp_a2, dp_b2, dp_c;
  logic               resp_valid, resp_id;
  logic [WIDTH-1:0]   resp_data;
  logic               busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_resp   = 0;
  exp_t sb [$];

  pipeline_issue_arbiter #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ops  (req0_ops),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_ops  (req1_ops),
    .req1_ready(req1_ready),
    .dp_a1     (dp_a1),
    .dp_b1     (dp_b1),
    .dp_a2     (dp_a2),
    .dp_b2     (dp_b2),
    .dp_c      (dp_c),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] c_of(input logic [4*WIDTH-1:0] ops);
    logic [WIDTH-1:0] a1, b1, a2, b2;
    {a1, b1, a2, b2} = ops;
    return (a1 * b1) + (a2 * b2);
  endfunction

  // Behavioural datapath model, deliberately without reset.
  logic [WIDTH-1:0] pipe [1:LATENCY];
  always @(posedge clk) begin
    pipe[1] <= c_of({dp_a1, dp_b1, dp_a2, dp_b2});
    for (int i = 2; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_c = pipe[LATENCY];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    check("drain_busy", busy, 0);
    step();
  endtask

  // Scoreboard: push on every accepted issue, pop and compare on each response.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      check("rst_ready", {req0_ready, req1_ready}, 0);
      check("rst_resp_valid", resp_valid, 0);
    end else begin
      if (req0_valid && req0_ready) sb.push_back('{id: 1'b0, c: c_of(req0_ops)});
      if (req1_valid && req1_ready) sb.push_back('{id: 1'b1, c: c_of(req1_ops)});
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", resp_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id", resp_id, e.id);
          check("resp_data", resp_data, e.c);
          n_resp++;
        end
      end
    end
  end

  initial begin
    logic       exp_g;
    logic       was;
    logic [7:0] pat4;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_ops   = '0;
    req1_ops   = '0;

    // 1. Reset state, then release with nothing valid.
    step();
    step();
    check("rst_dp", {dp_a1, dp_b1, dp_a2, dp_b2}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) step();
    check("idle_ready", {req0_ready, req1_ready}, 0);
    check("idle_resp", resp_valid, 0);
    check("idle_busy", busy, 0);

    // 2. Single issue from req0, operands registered, response after LATENCY.
    req0_ops   = {32'd0, 32'd1, 32'd2, 32'd3};
    req0_valid = 1'b1;
    #1;
    check("t2_ready0", req0_ready, 1);
    check("t2_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    check("t2_dp_a1", dp_a1, 0);
    check("t2_dp_b1", dp_b1, 1);
    check("t2_dp_a2", dp_a2, 2);
    check("t2_dp_b2", dp_b2, 3);
    check("t2_busy", busy, 1);
    check("t2_lat0", resp_valid, 0);
    for (int k = 1; k <= LATENCY; k++) begin
      step();
      check("t2_lat", resp_valid, (k == LATENCY) ? 64'd1 : 64'd0);
    end
    check("t2_resp_id", resp_id, 0);
    check("t2_resp_data", resp_data, 6);
    wait_idle();

    // 3. Both valid continuously; req0 won last, so req1 wins first, then alternate.
    req1_ops   = {32'd3, 32'd2, 32'd1, 32'd0};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    exp_g      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_ready0", req0_ready, !exp_g);
      check("t3_ready1", req1_ready, exp_g);
      step();
      exp_g = !exp_g;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // 4. req0 alone against its credit limit: two issues, then stalled until retires.
    pat4       = 8'b0011_0011; // bit i = expected req0_ready in cycle i
    req0_ops   = {WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom)};
    req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t4_ready0", req0_ready, pat4[i]);
      was = req0_ready;
      step();
      if (was)
        req0_ops = {WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom)};
    end
    req0_valid = 1'b0;
    wait_idle();

    // 5. Two operations in flight, then a one-cycle reset: both are lost.
    req0_valid = 1'b1;
    step();
    step();
    req0_valid = 1'b0;
    check("t5_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_busy_rst", busy, 0);
    check("t5_dp_rst", {dp_a1, dp_b1, dp_a2, dp_b2}, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 2 * LATENCY + 2; i++) begin
      check("t5_no_resp", resp_valid, 0);
      check("t5_busy", busy, 0);
      step();
    end
    req0_ops   = {32'd5, 32'd6, 32'd7, 32'd8};
    req0_valid = 1'b1;
    #1;
    check("t5_ready_after", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    wait_idle();

    // 6. req1 saturates its credits; req0 owns the grant until a req1 retire.
    req1_ops   = {32'd9, 32'd10, 32'd11, 32'd12};
    req1_valid = 1'b1;
    #1;
    check("t6_fill1_a", req1_ready, 1);
    step();
    check("t6_fill1_b", req1_ready, 1);
    step();
    req0_ops   = {32'd13, 32'd14, 32'd15, 32'd16};
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_ready0", req0_ready, (i < 2) ? 64'd1 : 64'd0);
      check("t6_ready1", req1_ready, (i < 2) ? 64'd0 : 64'd1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    repeat (2) step();

    check("sb_empty", sb.size(), 0);
    check("resp_count", n_resp, 19);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
